// File: rtl/regwb_pkg.sv
// ---------------------------------------------------------------------------
// regwb_pkg
// Shared definitions for the register-file writeback arbiter slice:
//   REQ_ALU / REQ_MEM : requester identifiers used by the round-robin arbiter
//   REG_ZERO / REG_RA : architectural register numbers of interest
//   wb_req_t          : packed writeback request {addr, data}
// ---------------------------------------------------------------------------
package regwb_pkg;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regwb_rr_arb.sv
// ---------------------------------------------------------------------------
// regwb_rr_arb
// Two-way round-robin arbiter between the ALU and load-unit writeback
// requesters. A lone valid requester is granted; on a tie the requester that
// was not granted last wins. The last-grant flop moves only on an accept.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   alu_valid, mem_valid request inputs
//   grant_alu, grant_mem one-hot (or zero) grant outputs, combinational
// ---------------------------------------------------------------------------
module regwb_rr_arb
    import regwb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic grant_alu,
    output logic grant_mem
);

    logic last_grant_r;

    // Grant selection: a tie goes to whoever did not win last time.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (alu_valid && mem_valid) begin
            grant_alu = (last_grant_r == REQ_MEM);
            grant_mem = (last_grant_r == REQ_ALU);
        end else begin
            grant_alu = alu_valid;
            grant_mem = mem_valid;
        end
    end

    // Last-grant history; reset to MEM so the ALU wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= REQ_MEM;
        end else if (grant_alu) begin
            last_grant_r <= REQ_ALU;
        end else if (grant_mem) begin
            last_grant_r <= REQ_MEM;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU (req 0) and the
// load unit (req 1) and keeps a busy scoreboard for RAW-hazard stalls.
// An accepted request is written to the register file one cycle later for
// exactly one cycle; writes to register 0 are accepted but never emitted.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   alu_valid/addr/data, alu_ready ALU writeback handshake
//   mem_valid/addr/data, mem_ready load writeback handshake
//   rsv_valid, rsv_addr            decode reserves a destination register
//   q_rs, q_rt -> q_rs_busy/q_rt_busy  scoreboard queries (combinational)
//   rf_we, rf_waddr, rf_wdata      registered register-file write port
// Optional feature macro REGWB_FWD_EN adds fwd_rs_hit, fwd_rt_hit, fwd_data:
//   the value being written this cycle is offered to decode and the matching
//   busy flag is masked.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regwb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] q_rs,
    input  logic [ADDR_W-1:0] q_rt,
    output logic              q_rs_busy,
    output logic              q_rt_busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
`ifdef REGWB_FWD_EN
    ,
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic              grant_alu_s;
    logic              grant_mem_s;
    logic              accept_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;

    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_waddr_r;
    logic [DATA_W-1:0] rf_wdata_r;

    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   busy_nxt_s;

    logic              rs_hit_s;
    logic              rt_hit_s;

    regwb_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .grant_alu (grant_alu_s),
        .grant_mem (grant_mem_s)
    );

    // Ready is the grant itself; grants are only issued to valid requesters.
    assign alu_ready = grant_alu_s;
    assign mem_ready = grant_mem_s;

    // Winner mux: the output stage never stalls, so any grant is an accept.
    always_comb begin
        accept_s = grant_alu_s | grant_mem_s;
        if (grant_mem_s) begin
            sel_addr_s = mem_addr;
            sel_data_s = mem_data;
        end else begin
            sel_addr_s = alu_addr;
            sel_data_s = alu_data;
        end
    end

    // Output register: one-cycle write pulse; register 0 writes are swallowed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {ADDR_W{1'b0}};
            rf_wdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            rf_we_r    <= (sel_addr_s != ZERO_ADDR);
            rf_waddr_r <= sel_addr_s;
            rf_wdata_r <= sel_data_s;
        end else begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= rf_waddr_r;
            rf_wdata_r <= rf_wdata_r;
        end
    end

    assign rf_we    = rf_we_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;

    // Scoreboard next state: clear on writeback, set on reserve; a set in the
    // same cycle as the clear of that register wins.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 1; i < NREG; i++) begin
            if (rsv_valid && (rsv_addr == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (rf_we_r && (rf_waddr_r == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

`ifdef REGWB_FWD_EN
    // Forward hits: the register being written this cycle is already usable.
    always_comb begin
        rs_hit_s = rf_we_r && (rf_waddr_r == q_rs) && (q_rs != ZERO_ADDR);
        rt_hit_s = rf_we_r && (rf_waddr_r == q_rt) && (q_rt != ZERO_ADDR);
    end

    assign fwd_rs_hit = rs_hit_s;
    assign fwd_rt_hit = rt_hit_s;
    assign fwd_data   = rf_wdata_r;
`else
    // Without forwarding a source stays busy through its writeback cycle.
    always_comb begin
        rs_hit_s = 1'b0;
        rt_hit_s = 1'b0;
    end
`endif

    // Scoreboard queries, masked by a forward hit when forwarding exists.
    always_comb begin
        if (rs_hit_s) begin
            q_rs_busy = 1'b0;
        end else begin
            q_rs_busy = busy_r[q_rs];
        end
        if (rt_hit_s) begin
            q_rt_busy = 1'b0;
        end else begin
            q_rt_busy = busy_r[q_rt];
        end
    end

endmodule
